regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have ports: clk  input  1  rising-edge clock; reset  input  1  asynchronous, active-low reset.
REQ-002 The block SHALL have ports: req0_valid/req1_valid  input  1  writeback request; req0_ready/req1_ready  output  1  grant/accept.
REQ-003 The block SHALL have ports: req0_reg/req1_reg  input  5  destination register; req0_data/req1_data  input  64  writeback value.
REQ-004 The block SHALL have ports: rf_WriteRegister  output  5; rf_WriteData  output  64; rf_RegWrite  output  1  (drive the register-file write port).
REQ-005 The block SHALL have ports: alloc_valid  input  1; alloc_reg  input  5  (issue-time destination reservation).
REQ-006 The block SHALL have ports: rd1_reg/rd2_reg  input  5  source registers; busy  output  32  pending-write scoreboard; stall  output  1  source hazard.

Function
REQ-007 reqN_ready SHALL be combinational from the valids and the priority state; a transfer SHALL occur when reqN_valid and reqN_ready are both 1 at a rising edge.
REQ-008 At most one of req0_ready/req1_ready SHALL be 1 in any cycle; a lone valid requester SHALL be granted in that same cycle.
REQ-009 When both requesters are valid, the requester selected by the priority state (REQ-020/021) SHALL be granted; the loser's ready SHALL be 0.
REQ-010 Requesters SHALL hold valid, reg and data stable until accepted; the block SHALL not depend on any other behaviour.
REQ-011 An accepted transfer SHALL be registered: on the next cycle rf_WriteRegister/rf_WriteData SHALL equal the accepted reg/data and rf_RegWrite SHALL be 1 for exactly that one cycle (latency 1).
REQ-012 An accepted transfer to register 31 SHALL be consumed with rf_RegWrite held 0 that cycle (X31 reads zero; writes are discarded).
REQ-013 With no transfer, rf_RegWrite SHALL be 0 and rf_WriteRegister/rf_WriteData SHALL hold their previous values.
REQ-014 alloc_valid=1 with alloc_reg=k (k<31) SHALL set busy[k] at the next edge; alloc_reg=31 SHALL be ignored; busy[31] SHALL be constant 0.
REQ-015 An accepted transfer to k (k<31) SHALL clear busy[k] at the edge of acceptance.
REQ-016 Alloc and clear of the same k at the same edge SHALL leave busy[k]=1 (set wins).
REQ-017 stall SHALL be combinational: stall = busy[rd1_reg] OR busy[rd2_reg] OR (rf_RegWrite AND rf_WriteRegister equals rd1_reg or rd2_reg), because the register file write lands one cycle after acceptance.
REQ-018 Back-to-back transfers on consecutive cycles SHALL be supported at full rate of one per cycle.

Reset
REQ-019 While reset=0, the block SHALL asynchronously force rf_RegWrite=0, rf_WriteRegister=0, rf_WriteData=0, busy=0, and priority state=0 (req0 preferred). reqN_ready SHALL be 0 while reset=0. A transfer in flight SHALL be dropped, and the first grant SHALL follow the first rising edge after reset deasserts.

Configuration
REQ-020 With macro WB_ROUND_ROBIN_EN defined, the block SHALL implement a 1-bit priority pointer. After an accepted transfer from requester i, the pointer SHALL point to the other requester. The pointer SHALL be unchanged when no transfer occurs.
REQ-021 Without WB_ROUND_ROBIN_EN, the block SHALL implement fixed priority: req0 SHALL always win contention, and no pointer state SHALL exist.

Verification
REQ-022 Reset mid-transfer: assert reset=0 while req0 is accepted -> rf_RegWrite=0 and busy=0 immediately; after release, req0_valid still high -> granted in the first cycle.
REQ-023 Lone request: req1 reg=5, data=64'hDEAD_BEEF_0000_0001 -> req1_ready=1 in the same cycle; next cycle rf_RegWrite=1, rf_WriteRegister=5, rf_WriteData=64'hDEAD_BEEF_0000_0001.
REQ-024 Contention: both valid for 4 cycles, regs 1 and 2 -> with WB_ROUND_ROBIN_EN, grants are 0,1,0,1; without it, grants are 0,0,0,0 and req1 is starved.
REQ-025 Scoreboard: alloc reg 7, then rd1_reg=7 -> stall=1. Writeback of reg 7 accepted -> busy[7]=0, stall remains 1 in the rf_RegWrite cycle, then stall=0.
REQ-026 X31: alloc 31 -> busy=0. Writeback to 31 with data 64'hFFFF_FFFF_FFFF_FFFF -> accepted, rf_RegWrite stays 0.
REQ-027 Set-wins: alloc reg 3 in the same cycle as an accepted writeback to 3 -> busy[3]=1 afterwards.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// regfile_wb_arbiter : two-port writeback arbiter with pending-write scoreboard
// Optional macro WB_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
// Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_wb_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [4:0]  req0_reg,
    input  logic [63:0] req0_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [4:0]  req1_reg,
    input  logic [63:0] req1_data,
    output logic [4:0]  rf_WriteRegister,
    output logic [63:0] rf_WriteData,
    output logic        rf_RegWrite,
    input  logic        alloc_valid,
    input  logic [4:0]  alloc_reg,
    input  logic [4:0]  rd1_reg,
    input  logic [4:0]  rd2_reg,
    output logic [31:0] busy,
    output logic        stall
);

    localparam logic [4:0] ZERO_REG = 5'd31;

    logic        grant0;
    logic        grant1;
    logic        xfer;
    logic [4:0]  sel_reg;
    logic [63:0] sel_data;

    logic [4:0]  wreg_q;
    logic [63:0] wdata_q;
    logic        wen_q;
    logic [30:0] busy_q, busy_d;
    logic [30:0] set_mask, clr_mask;

`ifdef WB_ROUND_ROBIN_EN
    logic prio_q, prio_d;

    // prio_q=0 prefers req0, prio_q=1 prefers req1
    always_comb begin
        grant0 = reset & req0_valid & (~req1_valid | ~prio_q);
        grant1 = reset & req1_valid & (~req0_valid |  prio_q);
        prio_d = prio_q;
        if (grant0 && req0_valid) begin
            prio_d = 1'b1;
        end else if (grant1 && req1_valid) begin
            prio_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`else
    always_comb begin
        grant0 = reset & req0_valid;
        grant1 = reset & req1_valid & ~req0_valid;
    end
`endif

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        xfer     = grant0 | grant1;
        sel_reg  = grant1 ? req1_reg  : req0_reg;
        sel_data = grant1 ? req1_data : req0_data;

        clr_mask = '0;
        set_mask = '0;
        if (xfer && (sel_reg != ZERO_REG)) begin
            clr_mask = 31'(1) << sel_reg;
        end
        if (alloc_valid && (alloc_reg != ZERO_REG)) begin
            set_mask = 31'(1) << alloc_reg;
        end
        // set applied after clear so a same-edge alloc keeps the register busy
        busy_d = (busy_q & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wreg_q  <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            busy_q  <= '0;
        end else begin
            busy_q <= busy_d;
            wen_q  <= xfer && (sel_reg != ZERO_REG);
            if (xfer) begin
                wreg_q  <= sel_reg;
                wdata_q <= sel_data;
            end
        end
    end

    assign rf_WriteRegister = wreg_q;
    assign rf_WriteData     = wdata_q;
    assign rf_RegWrite      = wen_q;
    assign busy             = {1'b0, busy_q};

    // the file write lands a cycle after acceptance, so the in-flight write also stalls
    assign stall = busy[rd1_reg] | busy[rd2_reg] |
                   (wen_q && ((wreg_q == rd1_reg) || (wreg_q == rd2_reg)));

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ============================================================================
// tb_regfile_wb_arbiter : directed self-checking bench for regfile_wb_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [4:0]  req0_reg, req1_reg;
    logic [63:0] req0_data, req1_data;
    logic [4:0]  rf_WriteRegister;
    logic [63:0] rf_WriteData;
    logic        rf_RegWrite;
    logic        alloc_valid;
    logic [4:0]  alloc_reg;
    logic [4:0]  rd1_reg, rd2_reg;
    logic [31:0] busy;
    logic        stall;

    int n_checks = 0;
    int n_err    = 0;

    localparam logic [63:0] DATA_A = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] DATA_D = 64'hDEAD_BEEF_0000_0001;

    regfile_wb_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .req0_valid       (req0_valid),
        .req0_ready       (req0_ready),
        .req0_reg         (req0_reg),
        .req0_data        (req0_data),
        .req1_valid       (req1_valid),
        .req1_ready       (req1_ready),
        .req1_reg         (req1_reg),
        .req1_data        (req1_data),
        .rf_WriteRegister (rf_WriteRegister),
        .rf_WriteData     (rf_WriteData),
        .rf_RegWrite      (rf_RegWrite),
        .alloc_valid      (alloc_valid),
        .alloc_reg        (alloc_reg),
        .rd1_reg          (rd1_reg),
        .rd2_reg          (rd2_reg),
        .busy             (busy),
        .stall            (stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic rr;
        logic exp_g1;
`ifdef WB_ROUND_ROBIN_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        reset = 1'b0;
        req0_valid = 1'b1; req0_reg = 5'd4; req0_data = DATA_A;
        req1_valid = 1'b0; req1_reg = 5'd0; req1_data = '0;
        alloc_valid = 1'b0; alloc_reg = 5'd0;
        rd1_reg = 5'd0; rd2_reg = 5'd0;
        #3;
        chk("reset_ready0", 64'(req0_ready), 64'd0);
        chk("reset_regwrite", 64'(rf_RegWrite), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_wdata", rf_WriteData, 64'd0);

        // release reset with req0 idle, reserve reg 9
        req0_valid = 1'b0;
        tick();
        reset = 1'b1;
        alloc_valid = 1'b1; alloc_reg = 5'd9;
        tick();
        alloc_valid = 1'b0;
        chk("alloc9_busy", 64'(busy), 64'(32'h0000_0200));

        // req0 accepted, then reset hits while the write is in flight
        req0_valid = 1'b1;
        #1;
        chk("lone0_ready", 64'(req0_ready), 64'd1);
        tick();
        chk("wb0_regwrite", 64'(rf_RegWrite), 64'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("midrst_regwrite", 64'(rf_RegWrite), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_ready0", 64'(req0_ready), 64'd0);
        tick();
        reset = 1'b1;
        #1;
        chk("postrst_ready0", 64'(req0_ready), 64'd1);
        tick();
        chk("postrst_regwrite", 64'(rf_RegWrite), 64'd1);
        chk("postrst_wdata", rf_WriteData, DATA_A);
        req0_valid = 1'b0;
        tick();
        chk("idle_regwrite", 64'(rf_RegWrite), 64'd0);
        chk("idle_hold_wdata", rf_WriteData, DATA_A);

        // lone req1
        req1_valid = 1'b1; req1_reg = 5'd5; req1_data = DATA_D;
        #1;
        chk("lone1_ready1", 64'(req1_ready), 64'd1);
        chk("lone1_ready0", 64'(req0_ready), 64'd0);
        tick();
        req1_valid = 1'b0;
        chk("lone1_regwrite", 64'(rf_RegWrite), 64'd1);
        chk("lone1_wreg", 64'(rf_WriteRegister), 64'd5);
        chk("lone1_wdata", rf_WriteData, DATA_D);

        // contention for four cycles
        req0_valid = 1'b1; req0_reg = 5'd1; req0_data = 64'd11;
        req1_valid = 1'b1; req1_reg = 5'd2; req1_data = 64'd22;
        for (int i = 0; i < 4; i++) begin
            exp_g1 = rr & i[0];
            #1;
            chk("cont_ready0", 64'(req0_ready), 64'(!exp_g1));
            chk("cont_ready1", 64'(req1_ready), 64'(exp_g1));
            tick();
            chk("cont_wreg", 64'(rf_WriteRegister), exp_g1 ? 64'd2 : 64'd1);
            chk("cont_wdata", rf_WriteData, exp_g1 ? 64'd22 : 64'd11);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // scoreboard hazard on reg 7
        rd1_reg = 5'd7;
        #1;
        chk("sb_nostall", 64'(stall), 64'd0);
        alloc_valid = 1'b1; alloc_reg = 5'd7;
        tick();
        alloc_valid = 1'b0;
        chk("sb_stall_busy", 64'(stall), 64'd1);
        req0_valid = 1'b1; req0_reg = 5'd7; req0_data = 64'd77;
        tick();
        req0_valid = 1'b0;
        chk("sb_busy7_clear", 64'(busy[7]), 64'd0);
        chk("sb_stall_inflight", 64'(stall), 64'd1);
        tick();
        chk("sb_stall_done", 64'(stall), 64'd0);
        rd1_reg = 5'd0;

        // register 31 is never busy and never written
        alloc_valid = 1'b1; alloc_reg = 5'd31;
        tick();
        alloc_valid = 1'b0;
        chk("x31_alloc_busy", 64'(busy), 64'd0);
        req1_valid = 1'b1; req1_reg = 5'd31; req1_data = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        chk("x31_ready1", 64'(req1_ready), 64'd1);
        tick();
        req1_valid = 1'b0;
        chk("x31_regwrite", 64'(rf_RegWrite), 64'd0);

        // set wins over clear on the same edge
        alloc_valid = 1'b1; alloc_reg = 5'd3;
        tick();
        rd2_reg = 5'd3;
        #1;
        chk("sw_stall_rd2", 64'(stall), 64'd1);
        req0_valid = 1'b1; req0_reg = 5'd3; req0_data = 64'd33;
        tick();
        alloc_valid = 1'b0; req0_valid = 1'b0;
        chk("sw_busy3", 64'(busy), 64'(32'h0000_0008));
        chk("sw_regwrite", 64'(rf_RegWrite), 64'd1);
        req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        chk("sw_clear3", 64'(busy), 64'd0);
        tick();
        chk("sw_final_stall", 64'(stall), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
